// File: rtl/onchip_ram_stream_master.sv
// Avalon-MM initiator that moves sample streams into and out of the on-chip RAM.
// Reads are credit-limited so the return FIFO can never overflow under back-pressure.
module onchip_ram_stream_master #(
    parameter int ADDR_W       = 14,
    parameter int DATA_W       = 32,
    parameter int BE_W         = 4,
    parameter int READ_LATENCY = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_read,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W:0]   cmd_len,
    input  logic              abort,
    input  logic [DATA_W-1:0] snk_data,
    input  logic              snk_valid,
    output logic              snk_ready,
    output logic [DATA_W-1:0] src_data,
    output logic              src_valid,
    input  logic              src_ready,
    output logic [ADDR_W-1:0] m_address,
    output logic [BE_W-1:0]   m_byteenable,
    output logic              m_chipselect,
    output logic              m_write,
    output logic [DATA_W-1:0] m_writedata,
    output logic              m_clken,
    input  logic [DATA_W-1:0] m_readdata,
    output logic              busy,
    output logic              done,
    output logic              done_abort
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     remain_q, remain_d;
    logic                abort_q, abort_d;
    logic [CW-1:0]       infl_q, infl_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [PW-1:0]       wptr_q, wptr_d;
    logic [PW-1:0]       rptr_q, rptr_d;
    logic [READ_LATENCY-1:0] pipe_q, pipe_d;
    logic [DATA_W-1:0]   fifo_q [FIFO_DEPTH];

    logic                cs_q, cs_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   adr_q, adr_d;
    logic [DATA_W-1:0]   wd_q, wd_d;
    logic [BE_W-1:0]     be_q, be_d;
    logic                clken_q, clken_d;

    logic                wr_beat;
    logic                rd_issue;
    logic                capture;
    logic                push;
    logic                pop;
    logic                flush;
    logic [CW:0]         used;

    assign cmd_ready  = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign done_abort = (state_q == S_DONE) && abort_q;

    assign snk_ready = (state_q == S_WRITE) && (remain_q != '0) && !abort_q;
    assign wr_beat   = snk_valid && snk_ready;

    // Credits cover every read decided but not yet landed in the FIFO.
    assign used     = {1'b0, infl_q} + {1'b0, cnt_q};
    assign rd_issue = (state_q == S_READ) && !abort_q && !abort
                   && (remain_q != '0)
                   && (used < (CW+1)'(FIFO_DEPTH));

    assign capture   = pipe_q[READ_LATENCY-1];
    assign flush     = abort_q || (abort && (state_q == S_READ));
    assign push      = capture && !flush;
    assign src_valid = (state_q == S_READ) && !abort_q && (cnt_q != '0);
    assign src_data  = src_valid ? fifo_q[rptr_q] : '0;
    assign pop       = src_valid && src_ready;

    assign m_address    = adr_q;
    assign m_byteenable = be_q;
    assign m_chipselect = cs_q;
    assign m_write      = we_q;
    assign m_writedata  = wd_q;
    assign m_clken      = clken_q;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        abort_d  = abort_q;
        cs_d     = 1'b0;
        we_d     = 1'b0;
        adr_d    = adr_q;
        wd_d     = wd_q;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    addr_d   = cmd_addr;
                    remain_d = cmd_len;
                    abort_d  = 1'b0;
                    if (cmd_len == '0)
                        state_d = S_DONE;
                    else if (cmd_read)
                        state_d = S_READ;
                    else
                        state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (wr_beat) begin
                    cs_d     = 1'b1;
                    we_d     = 1'b1;
                    adr_d    = addr_q;
                    wd_d     = snk_data;
                    addr_d   = addr_q + ADDR_W'(1);
                    remain_d = remain_q - (ADDR_W+1)'(1);
                end
                if (abort_q)
                    state_d = S_DONE;
                else if (abort)
                    abort_d = 1'b1;
                else if (remain_q == '0)
                    state_d = S_DONE;
            end
            S_READ: begin
                if (rd_issue) begin
                    cs_d     = 1'b1;
                    adr_d    = addr_q;
                    addr_d   = addr_q + ADDR_W'(1);
                    remain_d = remain_q - (ADDR_W+1)'(1);
                end
                if (abort_q) begin
                    if (infl_q == '0)
                        state_d = S_DONE;
                end else if (abort) begin
                    abort_d = 1'b1;
                end else if (remain_q == '0 && infl_q == '0 && cnt_q == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                abort_d = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
        be_d    = cs_d ? '1 : '0;
        clken_d = (state_d != S_IDLE);
    end

    always_comb begin
        pipe_d = READ_LATENCY'({pipe_q, cs_q & ~we_q});
        infl_d = infl_q + CW'(rd_issue) - CW'(capture);
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (push)
                wptr_d = wptr_q + PW'(1);
            if (pop)
                rptr_d = rptr_q + PW'(1);
            cnt_d = cnt_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            remain_q <= '0;
            abort_q  <= 1'b0;
            infl_q   <= '0;
            cnt_q    <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            pipe_q   <= '0;
            cs_q     <= 1'b0;
            we_q     <= 1'b0;
            adr_q    <= '0;
            wd_q     <= '0;
            be_q     <= '0;
            clken_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            remain_q <= remain_d;
            abort_q  <= abort_d;
            infl_q   <= infl_d;
            cnt_q    <= cnt_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            pipe_q   <= pipe_d;
            cs_q     <= cs_d;
            we_q     <= we_d;
            adr_q    <= adr_d;
            wd_q     <= wd_d;
            be_q     <= be_d;
            clken_q  <= clken_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_q[wptr_q] <= m_readdata;
    end

endmodule
